// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, scoreboard
// stage indices and the hard-wired zero register.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EX      = 2'd1,
    FWD_MEM     = 2'd2,
    FWD_WB      = 2'd3
  } fwd_sel_e;

  localparam int STAGE_EX  = 0;
  localparam int STAGE_MEM = 1;
  localparam int STAGE_WB  = 2;

  localparam logic [4:0] NO_REG = 5'd0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Match one ID source register against the EX/MEM/WB scoreboard; returns the
// youngest-producer forwarding select and whether that source hits a pending load.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic        id_valid_i,
  input  logic        rs_ena_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [2:0]  vld_i,
  input  logic [14:0] rd_i,
  input  logic [1:0]  ld_i,
  output logic [1:0]  sel_o,
  output logic        lu_o
);

  logic [2:0] match;
  fwd_sel_e   sel;

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      match[s] = id_valid_i & rs_ena_i & (rs_addr_i != NO_REG) & vld_i[s] &
                 (rd_i[s*5 +: 5] == rs_addr_i);
    end
  end

  // Load data only exists once the load reaches WB, so EX/MEM hits are hazards.
  assign lu_o = (match[STAGE_EX] & ld_i[STAGE_EX]) | (match[STAGE_MEM] & ld_i[STAGE_MEM]);

  always_comb begin
    sel = FWD_REGFILE;
    if (match[STAGE_EX])       sel = FWD_EX;
    else if (match[STAGE_MEM]) sel = FWD_MEM;
    else if (match[STAGE_WB])  sel = FWD_WB;
  end

  assign sel_o = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside id_stage: tracks in-flight destinations in EX/MEM/WB,
// drives stall/bubble/flush and operand-forwarding selects, counts stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs1_ena,
  input  logic [4:0]       id_rs1_addr,
  input  logic             id_rs2_ena,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rd_ena,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic             if_id_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [STAGES-1:0]      vld_q, vld_d;
  logic [STAGES-1:0][4:0] rd_q, rd_d;
  // The load flag is only consulted in EX and MEM; WB data is always forwardable.
  logic [1:0]             ld_q, ld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [1:0] sel1, sel2;
  logic       lu1, lu2, lu;

  hazard_fwd_sel u_fwd_rs1 (
    .id_valid_i (id_valid),
    .rs_ena_i   (id_rs1_ena),
    .rs_addr_i  (id_rs1_addr),
    .vld_i      (vld_q),
    .rd_i       (rd_q),
    .ld_i       (ld_q),
    .sel_o      (sel1),
    .lu_o       (lu1)
  );

  hazard_fwd_sel u_fwd_rs2 (
    .id_valid_i (id_valid),
    .rs_ena_i   (id_rs2_ena),
    .rs_addr_i  (id_rs2_addr),
    .vld_i      (vld_q),
    .rd_i       (rd_q),
    .ld_i       (ld_q),
    .sel_o      (sel2),
    .lu_o       (lu2)
  );

  assign lu = lu1 | lu2;

  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_bubble   = 1'b0;
    if_id_flush = 1'b0;
    if (rst) begin
      // all controls held low
    end else if (mem_stall) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      ex_bubble   = 1'b1;
    end else if (lu) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
    end
  end

  assign fwd_rs1_sel = (rst | lu) ? FWD_REGFILE : sel1;
  assign fwd_rs2_sel = (rst | lu) ? FWD_REGFILE : sel2;
  assign stall_cnt   = rst ? '0 : cnt_q;

  always_comb begin
    vld_d = vld_q;
    rd_d  = rd_q;
    ld_d  = ld_q;
    if (!mem_stall) begin
      vld_d[STAGE_WB]  = vld_q[STAGE_MEM];
      vld_d[STAGE_MEM] = vld_q[STAGE_EX];
      rd_d[STAGE_WB]   = rd_q[STAGE_MEM];
      rd_d[STAGE_MEM]  = rd_q[STAGE_EX];
      ld_d[STAGE_MEM]  = ld_q[STAGE_EX];
      // Wrong-path and stalled instructions must not claim a destination.
      vld_d[STAGE_EX]  = id_valid & id_rd_ena & (id_rd_addr != NO_REG) & ~ex_redirect & ~lu;
      rd_d[STAGE_EX]   = id_rd_addr;
      ld_d[STAGE_EX]   = id_is_load;
    end
    cnt_d = id_stall ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: payload fields are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    rd_q <= rd_d;
    ld_q <= ld_d;
  end

endmodule
